// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared types and constants for the SD card SPI byte engine
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  localparam logic [7:0] SD_SPI_FILL_BYTE = 8'hFF;
  localparam int SD_SPI_SLOW_HP = 60;
  localparam int SD_SPI_FAST_HP = 1;
  localparam int SD_SPI_HP_W = 6;
endpackage

// File: rtl/sd_spi_tick.sv
// sd_spi_tick: half-bit timer, one-cycle tick every period cycles while run
//   load   reload from period (burst accept)
//   run    count down while a burst is in progress
//   period half-period in clk cycles (1..63)
//   tick   half-bit boundary strobe
module sd_spi_tick
  import sd_spi_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   run,
  input  logic [SD_SPI_HP_W-1:0] period,
  output logic                   tick
);
  logic [SD_SPI_HP_W-1:0] cnt;
  assign tick = run && cnt == SD_SPI_HP_W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load || tick) cnt <= period;
    else if (run) cnt <= cnt - 1'b1;
endmodule

// File: rtl/sd_spi_engine.sv
// sd_spi_engine: SPI mode 0 byte-burst transceiver for an SD card (MSB first)
//   start/tx_data/len/cs_assert  burst request (len = bytes-1), accepted when idle
//   fast                         fast half-period select, present only with SD_SPI_FAST_EN
//   busy/rx_data/rx_valid/done   burst status and received bytes
//   spi_cs/spi_clk/spi_do/spi_di SD card SPI pins
module sd_spi_engine
  import sd_spi_pkg::*;
#(
  parameter int SLOW_HALF_PERIOD = SD_SPI_SLOW_HP,
  parameter int FAST_HALF_PERIOD = SD_SPI_FAST_HP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic [9:0] len,
  input  logic       cs_assert,
`ifdef SD_SPI_FAST_EN
  input  logic       fast,
`endif
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       spi_cs,
  output logic       spi_clk,
  output logic       spi_do,
  input  logic       spi_di
);
`ifndef SD_SPI_FAST_EN
  logic fast;
  assign fast = 1'b0;
`endif
  state_t state;
  logic [SD_SPI_HP_W-1:0] hp, sel_hp;
  logic [7:0] shift;
  logic [2:0] bit_count;
  logic [9:0] byte_count;
  logic accept, tick;
  assign sel_hp = fast ? SD_SPI_HP_W'(FAST_HALF_PERIOD) : SD_SPI_HP_W'(SLOW_HALF_PERIOD);
  assign accept = state == IDLE && start;
  // the timer must see the new half-period on the accept edge, before hp is latched
  sd_spi_tick u_tick (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .run(busy),
    .period(accept ? sel_hp : hp),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      rx_valid <= 1'b0;
      done <= 1'b0;
      rx_data <= '0;
      spi_cs <= 1'b1;
      spi_clk <= 1'b0;
      spi_do <= 1'b1;
      shift <= '0;
      bit_count <= '0;
      byte_count <= '0;
      hp <= SD_SPI_HP_W'(SLOW_HALF_PERIOD);
    end else begin
      rx_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          spi_clk <= 1'b0;
          spi_do <= start ? tx_data[7] : 1'b1;
          spi_cs <= ~cs_assert;
          if (start) begin
            shift <= tx_data;
            byte_count <= len;
            hp <= sel_hp;
            bit_count <= '0;
            busy <= 1'b1;
            state <= LOW;
          end
        end
        LOW: if (tick) begin
          spi_clk <= 1'b1;
          shift <= {shift[6:0], spi_di};
          state <= HIGH;
        end
        HIGH: if (tick) begin
          spi_clk <= 1'b0;
          if (bit_count != 3'd7) begin
            bit_count <= bit_count + 3'd1;
            spi_do <= shift[7];
            state <= LOW;
          end else begin
            rx_data <= shift;
            rx_valid <= 1'b1;
            bit_count <= '0;
            if (byte_count == '0) begin
              done <= 1'b1;
              busy <= 1'b0;
              spi_do <= 1'b1;
              state <= IDLE;
            end else begin
              // later bytes of a burst clock out fill so the card sees idle MOSI
              byte_count <= byte_count - 10'd1;
              shift <= SD_SPI_FILL_BYTE;
              spi_do <= SD_SPI_FILL_BYTE[7];
              state <= LOW;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/sd_spi_engine.md
# sd_spi_engine

Byte-level SPI transceiver sitting directly downstream of the SD card pager: the pager issues command bytes and sector-read bursts, and this block shifts them onto the SD card's SPI pins and returns the received bytes. It owns the SPI clock divider, chip-select register and bit timing (SPI mode 0, MSB first). Bursts of up to 1024 bytes, with 0xFF fill after the first byte, let a whole 512-byte sector plus CRC be read with one request.

## Interface
- SLOW_HALF_PERIOD, 60: clk cycles per SPI half-bit in slow mode (12 MHz / 120 = 100 kHz); legal 1..63.
- FAST_HALF_PERIOD, 1: clk cycles per half-bit in fast mode; legal 1..63.
- clk  input  1  system clock; one clock domain.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a burst; accepted only when busy==0.
- tx_data  input  8  first byte of the burst, latched on accept.
- len  input  10  burst length minus one (0 = 1 byte, 513 = 514 bytes), latched on accept.
- cs_assert  input  1  1 = drive chip select active (low).
- fast  input  1  select FAST_HALF_PERIOD for this burst (only with SD_SPI_FAST_EN).
- busy  output  1  burst in progress.
- rx_data  output  8  last received byte, held until the next rx_valid.
- rx_valid  output  1  one-cycle pulse per received byte.
- done  output  1  one-cycle pulse with the final rx_valid of a burst.
- spi_cs  output  1  SD chip select, active low.
- spi_clk  output  1  SPI clock; idles low.
- spi_do  output  1  MOSI; idles high.
- spi_di  input  1  MISO.

## Operation
- States: IDLE, LOW, HIGH.
- IDLE:
  - spi_clk=0, spi_do=1.
  - spi_cs <= ~cs_assert every cycle.
  - On start: latch tx_data into the shift register, latch len into the byte counter, latch the half-period, clear bit_count, busy<=1, go to LOW.
- LOW:
  - On entry, spi_clk=0 and spi_do=shift[7].
  - Hold for half-period cycles, then go to HIGH.
- HIGH:
  - On entry, spi_clk=1 and spi_di is sampled into shift[0] while the register shifts left.
  - Hold for half-period cycles.
  - If bit_count != 7: bit_count+1, go to LOW.
  - Else:
    - rx_data<=received byte, rx_valid<=1.
    - If byte counter==0: done<=1, busy<=0, go to IDLE.
    - Else: decrement the counter, load shift=0xFF, go to LOW with no gap.
- spi_cs is frozen while busy; a cs_assert change takes effect the first IDLE cycle after done.
- start while busy==1 is ignored; it is not queued.
- Bit counter is 3 bits and the byte counter 10 bits. Both wrap only through reload, never by overflow.
- Reset (any time, including mid-burst):
  - Go to IDLE.
  - busy=0, rx_valid=0, done=0, rx_data=0x00.
  - spi_cs=1, spi_clk=0, spi_do=1.
  - Partial byte discarded.

## Timing
- Start accepted at edge N: busy=1, spi_clk=0, spi_do=tx_data[7] visible after edge N.
- Each half-bit lasts exactly H cycles, where H is the latched half-period. A byte takes 16·H cycles.
- rx_valid for byte k is asserted 16·H·(k+1) cycles after the accept edge, for one cycle.
- done and busy=0 coincide with the last rx_valid. A start in that same cycle is accepted: back-to-back bursts have a one-cycle IDLE gap.
- Burst total: 16·H·(len+1) cycles + 1 IDLE cycle.
- spi_di is sampled on the cycle spi_clk rises. The card must present data H cycles before the rise.

## Configuration
- SD_SPI_FAST_EN defined:
  - fast port exists and is sampled on accept.
  - fast=1 uses FAST_HALF_PERIOD, fast=0 uses SLOW_HALF_PERIOD.
- Undefined:
  - fast port absent.
  - Half-period always SLOW_HALF_PERIOD; FAST_HALF_PERIOD unused.

## Structure
- Package sd_spi_pkg holds:
  - state enum (IDLE/LOW/HIGH);
  - SD_SPI_FILL_BYTE = 8'hFF;
  - default half-period constants 60 and 1;
  - 6-bit half-period counter width.
- Sub-module sd_spi_tick: 6-bit down-counter loaded with the latched half-period, emitting a one-cycle tick at each half-bit boundary. The main FSM advances only on tick.

## Test plan
- Reset mid-burst (after 3 bits at H=60) -> next cycle spi_cs=1, spi_clk=0, spi_do=1, busy=0, rx_valid never pulses; a new start then works normally.
- Single byte: cs_assert=1, tx_data=0x40, len=0, card returns 0xA5 -> MOSI bits 0,1,0,0,0,0,0,0 on rising edges; rx_data=0xA5; rx_valid and done at cycle 960 after accept; spi_cs=0 throughout.
- Sector burst: tx_data=0xFF, len=513, card streams 0x00..0xFF ramp twice plus CRC 0x12,0x34 -> 514 rx_valid pulses with matching data; MOSI stays 1; done only on pulse 514.
- Back-to-back: start held high through done -> second burst begins one cycle after done; spi_cs unchanged unless cs_assert toggled.
- Ignored start: pulse start mid-burst with tx_data=0x51 -> no effect on shift data or length.
- With SD_SPI_FAST_EN: fast=1, len=0 -> spi_clk period 2 cycles, done 16 cycles after accept.
